// File: rtl/me_mem_server.sv
// me_mem_server: frame memories and run/result controller for a motion estimator (watchdog enabled by ME_SERVER_TIMEOUT_EN)
module me_mem_server #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_valid,
  input  logic       load_sel,
  input  logic [9:0] load_addr,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       run,
  output logic       busy,
  output logic       start,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  input  logic       completed,
  input  logic [7:0] BestDist,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  output logic       res_valid,
  output logic [7:0] res_dist,
  output logic [3:0] res_mx,
  output logic [3:0] res_my,
  input  logic       res_ack,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [7:0] mem_r [256];
  logic [7:0] mem_s [1024];
  logic expire;
  assign load_ready = state == IDLE;
  assign busy = state != IDLE;
`ifdef ME_SERVER_TIMEOUT_EN
  logic [15:0] cnt;
  assign expire = cnt + 16'd1 == TIMEOUT_CYCLES;
  // watchdog: cleared on run acceptance, counts every cycle spent in RUN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state == IDLE && run) cnt <= '0;
    else if (state == RUN) cnt <= cnt + 16'd1;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  // memory writes are only accepted while idle; contents survive reset
  always_ff @(posedge clock)
    if (load_valid && state == IDLE) begin
      if (load_sel) mem_s[load_addr] <= load_data;
      else mem_r[load_addr[7:0]] <= load_data;
    end
  // registered reads every cycle; same-cycle write returns old data
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      R <= '0;
      S1 <= '0;
      S2 <= '0;
    end else begin
      R <= mem_r[AddressR];
      S1 <= mem_s[AddressS1];
      S2 <= mem_s[AddressS2];
    end
  // run controller: launch estimator, capture result or watchdog expiry, hold until acknowledged
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      start <= 1'b0;
      res_valid <= 1'b0;
      timeout <= 1'b0;
      res_dist <= '0;
      res_mx <= '0;
      res_my <= '0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state <= RUN;
          start <= 1'b1;
        end
        RUN: if (completed) begin
          state <= DONE;
          start <= 1'b0;
          res_valid <= 1'b1;
          timeout <= 1'b0;
          res_dist <= BestDist;
          res_mx <= motionX;
          res_my <= motionY;
        end else if (expire) begin
          state <= DONE;
          start <= 1'b0;
          res_valid <= 1'b1;
          timeout <= 1'b1;
          res_dist <= 8'hFF;
          res_mx <= '0;
          res_my <= '0;
        end
        DONE: if (res_ack) begin
          state <= IDLE;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_me_mem_server.sv
// tb_me_mem_server: directed test of me_mem_server against a behavioural model
module tb_me_mem_server;
  localparam int TO = 65535;
`ifdef ME_SERVER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load_valid = 1'b0, load_sel = 1'b0;
  logic [9:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic load_ready, run = 1'b0, busy, start;
  logic [7:0] AddressR = '0;
  logic [9:0] AddressS1 = '0, AddressS2 = '0;
  logic [7:0] R, S1, S2;
  logic completed = 1'b0;
  logic [7:0] BestDist = '0;
  logic [3:0] motionX = '0, motionY = '0;
  logic res_valid, res_ack = 1'b0, timeout;
  logic [7:0] res_dist;
  logic [3:0] res_mx, res_my;
  int n_chk = 0, n_fail = 0;

  me_mem_server dut (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready), .run(run),
    .busy(busy), .start(start), .AddressR(AddressR), .AddressS1(AddressS1),
    .AddressS2(AddressS2), .R(R), .S1(S1), .S2(S2), .completed(completed),
    .BestDist(BestDist), .motionX(motionX), .motionY(motionY), .res_valid(res_valid),
    .res_dist(res_dist), .res_mx(res_mx), .res_my(res_my), .res_ack(res_ack),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 running, 2 result pending
  int ph = 0, rc = 0;
  logic [7:0] mr [256];
  logic [7:0] ms [1024];
  bit kr [256];
  bit ks [1024];
  logic [7:0] er = 0, es1 = 0, es2 = 0, ed = 0;
  bit erk = 1, es1k = 1, es2k = 1, eto = 0;
  logic [3:0] ex = 0, ey = 0;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ph = 0; rc = 0; er = 0; es1 = 0; es2 = 0; erk = 1; es1k = 1; es2k = 1;
      ed = 0; ex = 0; ey = 0; eto = 0;
    end else begin
      er = mr[AddressR]; erk = kr[AddressR];
      es1 = ms[AddressS1]; es1k = ks[AddressS1];
      es2 = ms[AddressS2]; es2k = ks[AddressS2];
      if (ph == 0 && load_valid) begin
        if (load_sel) begin ms[load_addr] = load_data; ks[load_addr] = 1; end
        else begin mr[load_addr[7:0]] = load_data; kr[load_addr[7:0]] = 1; end
      end
      if (ph == 0) begin
        if (run) begin ph = 1; rc = 0; end
      end else if (ph == 1) begin
        rc++;
        if (completed) begin ph = 2; ed = BestDist; ex = motionX; ey = motionY; eto = 0; end
        else if (TO_EN && rc == TO) begin ph = 2; ed = 8'hFF; ex = 0; ey = 0; eto = 1; end
      end else if (res_ack) ph = 0;
    end

  always @(negedge clock)
    if (reset_n) begin
      chk("load_ready", load_ready, ph == 0);
      chk("busy", busy, ph != 0);
      chk("start", start, ph == 1);
      chk("res_valid", res_valid, ph == 2);
      chk("res_dist", res_dist, ed);
      chk("res_mx", res_mx, ex);
      chk("res_my", res_my, ey);
      chk("timeout", timeout, eto);
      if (erk) chk("R", R, er);
      if (es1k) chk("S1", S1, es1);
      if (es2k) chk("S2", S2, es2);
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic sel, input logic [9:0] a, input logic [7:0] d);
    load_valid = 1; load_sel = sel; load_addr = a; load_data = d;
    tick(1);
    load_valid = 0;
  endtask

  initial begin
    tick(2);
    chk("rst load_ready", load_ready, 1); chk("rst busy", busy, 0);
    chk("rst start", start, 0); chk("rst res_valid", res_valid, 0);
    chk("rst R", R, 0); chk("rst S1", S1, 0); chk("rst dist", res_dist, 0);
    chk("rst timeout", timeout, 0);
    reset_n = 1;
    tick(1);
    load(0, 10'd5, 8'h3C);
    load(1, 10'd700, 8'hA1);
    load(0, 10'd6, 8'h77);
    load(0, 10'h3FF, 8'h11);
    load(1, 10'd1023, 8'h5A);
    AddressR = 5; AddressS1 = 700; AddressS2 = 700;
    tick(1);
    chk("R[5]", R, 8'h3C); chk("S1[700]", S1, 8'hA1); chk("S2[700]", S2, 8'hA1);
    AddressR = 8'hFF; AddressS1 = 10'd1023;
    tick(1);
    chk("R[255] hi bits ignored", R, 8'h11); chk("S1[1023]", S1, 8'h5A);
    AddressR = 6;
    load(0, 10'd6, 8'h99);
    chk("R old data", R, 8'h77);
    tick(1);
    chk("R new data", R, 8'h99);
    run = 1; load_valid = 1; load_sel = 1; load_addr = 10'd3; load_data = 8'h42;
    tick(1);
    run = 0; load_valid = 0;
    chk("start after run", start, 1); chk("busy in run", busy, 1);
    chk("load_ready in run", load_ready, 0);
    load(0, 10'd5, 8'h00);
    run = 1; res_ack = 1;
    tick(3);
    run = 0; res_ack = 0;
    chk("still running", start, 1);
    completed = 1; BestDist = 8'h12; motionX = 3; motionY = 9;
    tick(1);
    BestDist = 8'h34; motionX = 7; motionY = 1;
    chk("done start", start, 0); chk("done res_valid", res_valid, 1);
    chk("done dist", res_dist, 8'h12); chk("done mx", res_mx, 3); chk("done my", res_my, 9);
    tick(3);
    completed = 0;
    chk("held dist", res_dist, 8'h12);
    res_ack = 1;
    tick(1);
    res_ack = 0;
    chk("ack res_valid", res_valid, 0); chk("ack busy", busy, 0);
    chk("persist dist", res_dist, 8'h12); chk("persist my", res_my, 9);
    AddressR = 5; AddressS1 = 3;
    tick(1);
    chk("R[5] unchanged", R, 8'h3C); chk("S1[3] same-cycle write", S1, 8'h42);
    run = 1;
    tick(1);
    run = 0;
    if (TO_EN) begin
      for (int i = 0; i < 70000 && !res_valid; i++) tick(1);
      chk("wd res_valid", res_valid, 1); chk("wd dist", res_dist, 8'hFF);
      chk("wd timeout", timeout, 1); chk("wd mx", res_mx, 0);
      res_ack = 1;
      tick(1);
      res_ack = 0; run = 1;
      tick(1);
      run = 0;
    end else begin
      tick(70000);
      chk("no wd busy", busy, 1); chk("no wd start", start, 1);
      chk("no wd timeout", timeout, 0);
    end
    AddressS1 = 700;
    #2 reset_n = 0;
    #1 chk("async start", start, 0); chk("async busy", busy, 0);
    chk("async res_valid", res_valid, 0); chk("async S1", S1, 0);
    tick(1);
    reset_n = 1;
    tick(1);
    chk("mem kept", S1, 8'hA1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
